// File: rtl/ddc_ctrl_pkg.sv
// Shared types and default constants for the digital downconverter controller.
package ddc_ctrl_pkg;

    // Controller operating modes
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } ddc_state_t;

    localparam int DEF_PHASE_W  = 32;
    localparam int DEF_SETTLE_N = 16;
    localparam int DEF_CNT_W    = 16;

endpackage : ddc_ctrl_pkg

// File: rtl/ddc_nco_acc.sv
// NCO phase accumulator with a phase-offset adder on its output.
// clr has priority over adv; all arithmetic wraps modulo 2^PHASE_W.
module ddc_nco_acc #(
    parameter int PHASE_W = ddc_ctrl_pkg::DEF_PHASE_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               adv,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [PHASE_W-1:0] poff,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] r_acc;

    // Accumulator: clear, advance by fcw on a sample, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (adv) begin
            r_acc <= r_acc + fcw;
        end
    end

    // Mixer phase for the current sample uses the accumulator before its advance
    always_comb begin
        phase = r_acc + poff;
    end

endmodule : ddc_nco_acc

// File: rtl/ddc_ctrl.sv
// Downconverter controller: NCO tuning, settle blanking and retune bookkeeping.
//
// Config handshake: a config is taken on any cycle where cfg_valid && cfg_ready.
// cfg_ready depends only on the mode (high in IDLE and RUN, low in SETTLE).
// In RUN a config taken while enable is low is dropped, since stopping wins.
module ddc_ctrl
    import ddc_ctrl_pkg::*;
#(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int SETTLE_N = DEF_SETTLE_N,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               smp_valid,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fcw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic               cfg_prst,
    output logic [PHASE_W-1:0] nco_phase,
    output logic               nco_valid,
    output logic               out_valid,
    output logic               busy,
    output logic [CNT_W-1:0]   retune_cnt
);

    localparam int SC_W = $clog2(SETTLE_N + 2);
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_N);
    localparam ddc_state_t ST_AFTER_TUNE = (SETTLE_N == 0) ? ST_RUN : ST_SETTLE;

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    ddc_state_t         r_state;
    ddc_state_t         w_state_next;
    logic [SC_W-1:0]    r_cnt;
    logic [SC_W-1:0]    w_cnt_next;
    logic [PHASE_W-1:0] r_fcw;
    logic [PHASE_W-1:0] r_poff;
    logic [PHASE_W-1:0] w_phase;
    logic               w_cfg_take;
    logic               w_apply;
    logic               w_adv;
    logic               w_clr;

    // Reset synchroniser: asserts immediately, releases two edges later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Handshake, config apply and sample-advance qualifiers
    always_comb begin
        cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
        busy       = (r_state == ST_SETTLE);
        w_cfg_take = cfg_valid && cfg_ready;
        w_apply    = w_cfg_take && ((r_state == ST_IDLE) || enable);
        w_adv      = smp_valid && enable && (r_state != ST_IDLE);
        w_clr      = (w_state_next == ST_IDLE) || (w_apply && cfg_prst);
    end

    // Next-state and settle-counter logic; enable low overrides everything
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_AFTER_TUNE;
                    w_cnt_next   = SC_LOAD;
                end
                ST_SETTLE: begin
                    if (smp_valid) begin
                        if (r_cnt <= SC_W'(1)) begin
                            w_state_next = ST_RUN;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt - SC_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (w_cfg_take) begin
                        w_state_next = ST_AFTER_TUNE;
                        w_cnt_next   = SC_LOAD;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Mode and settle counter registers
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Active tuning registers and retune counter
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fcw      <= '0;
            r_poff     <= '0;
            retune_cnt <= '0;
        end else if (w_apply) begin
            r_fcw      <= cfg_fcw;
            r_poff     <= cfg_poff;
            retune_cnt <= retune_cnt + CNT_W'(1);
        end
    end

    // Registered mixer phase, sample tag and settled flag
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            nco_phase <= '0;
            nco_valid <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            nco_valid <= w_adv;
            out_valid <= (w_state_next == ST_RUN);
            if (w_adv) begin
                nco_phase <= w_phase;
            end
        end
    end

    ddc_nco_acc #(
        .PHASE_W (PHASE_W)
    ) u_nco_acc (
        .clk     (clk),
        .reset_n (w_rst_n),
        .clr     (w_clr),
        .adv     (w_adv),
        .fcw     (r_fcw),
        .poff    (r_poff),
        .phase   (w_phase)
    );

endmodule : ddc_ctrl

// File: tb/tb_ddc_ctrl.sv
// Self-checking bench for ddc_ctrl against a behavioural model of the tuner.
module tb_ddc_ctrl;
  localparam int PW = 32;
  localparam int SN = 16;
  localparam int CW = 16;
  localparam int M_IDLE = 0;
  localparam int M_SETTLE = 1;
  localparam int M_RUN = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic smp_valid = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_prst = 1'b0;
  logic [PW-1:0] cfg_fcw = '0;
  logic [PW-1:0] cfg_poff = '0;
  logic cfg_ready;
  logic [PW-1:0] nco_phase;
  logic nco_valid;
  logic out_valid;
  logic busy;
  logic [CW-1:0] retune_cnt;

  always #5 clk = ~clk;

  ddc_ctrl #(.PHASE_W(PW), .SETTLE_N(SN), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .smp_valid  (smp_valid),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_fcw    (cfg_fcw),
    .cfg_poff   (cfg_poff),
    .cfg_prst   (cfg_prst),
    .nco_phase  (nco_phase),
    .nco_valid  (nco_valid),
    .out_valid  (out_valid),
    .busy       (busy),
    .retune_cnt (retune_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode;
  int m_left;
  logic [PW-1:0] m_acc;
  logic [PW-1:0] m_fcw;
  logic [PW-1:0] m_poff;
  logic [CW-1:0] m_ret;
  logic [PW-1:0] e_phase;
  bit e_nvalid;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_left = 0;
    m_acc = '0;
    m_fcw = '0;
    m_poff = '0;
    m_ret = '0;
    e_phase = '0;
    e_nvalid = 1'b0;
  endtask

  // Expected mixer phases of a directed run, filled by the bench
  logic [PW-1:0] exp_q[$];

  // ---------------- driver ----------------
  task automatic cycle(input bit en, input bit sv, input bit cv,
                       input logic [PW-1:0] f, input logic [PW-1:0] p, input bit pr);
    bit ready, taken, apply, adv;
    @(negedge clk);
    enable = en;
    smp_valid = sv;
    cfg_valid = cv;
    cfg_fcw = f;
    cfg_poff = p;
    cfg_prst = pr;
    #1;
    ready = (m_mode != M_SETTLE);
    check_eq("cfg_ready", cfg_ready, ready);
    taken = ready && cv;
    apply = taken && (m_mode == M_IDLE || en);
    adv = sv && en && (m_mode != M_IDLE);
    e_nvalid = adv;
    if (adv) begin
      e_phase = m_acc + m_poff;
      m_acc = m_acc + m_fcw;
    end
    if (!en || (apply && pr)) m_acc = '0;
    if (apply) begin
      m_fcw = f;
      m_poff = p;
      m_ret = m_ret + 1'b1;
    end
    if (!en) begin
      m_mode = M_IDLE;
      m_left = 0;
    end else if (m_mode == M_IDLE || (m_mode == M_RUN && taken)) begin
      m_left = SN;
      m_mode = (SN == 0) ? M_RUN : M_SETTLE;
    end else if (m_mode == M_SETTLE && sv) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = M_RUN;
    end
    @(posedge clk);
    #1;
    check_eq("nco_valid", nco_valid, e_nvalid);
    check_eq("nco_phase", nco_phase, e_phase);
    check_eq("out_valid", out_valid, m_mode == M_RUN);
    check_eq("busy", busy, m_mode == M_SETTLE);
    check_eq("retune_cnt", retune_cnt, m_ret);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_phase"}, nco_phase, 0);
    check_eq({tag, "_nvalid"}, nco_valid, 0);
    check_eq({tag, "_ovalid"}, out_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_retune"}, retune_cnt, 0);
    check_eq({tag, "_ready"}, cfg_ready, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, 0);
  endtask

  // Runs enabled cycles and checks the number of samples until out_valid rises
  task automatic settle_run(input int n_cyc, input int gap, input bit chk_seq);
    int samples;
    bit seen;
    logic [PW-1:0] want;
    samples = 0;
    seen = 0;
    for (int i = 0; i < n_cyc; i++) begin
      cycle(1, (i % gap) == 0, 0, '0, '0, 0);
      if (nco_valid) begin
        samples++;
        if (chk_seq) begin
          if (exp_q.size() == 0) check_eq("seq_underflow", 1, 0);
          else begin
            want = exp_q.pop_front();
            check_eq("seq_phase", nco_phase, want);
          end
        end
      end
      if (out_valid && !seen) begin
        seen = 1;
        check_eq("settle_len", samples, SN);
      end
    end
    check_eq("settled", seen, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CW-1:0] ret_before;
    int guard;
    model_reset();

    // Reset state
    #1;
    check_all_zero("rst");
    #21 reset_n = 1'b1;
    idle_cycles(3);

    // Quarter-rate tone: 0, 1/4, 1/2, 3/4 turns repeating
    cycle(0, 0, 1, 32'h4000_0000, 32'h0, 0);
    for (int k = 0; k < 24; k++) exp_q.push_back(PW'(k) * 32'h4000_0000);
    cycle(1, 0, 0, '0, '0, 0);
    settle_run(23, 1, 1);
    exp_q.delete();

    // Phase-continuous retune from RUN
    ret_before = retune_cnt;
    cycle(1, 1, 1, 32'h2000_0000, 32'h0, 0);
    check_eq("retune_inc", retune_cnt, ret_before + 1'b1);
    check_eq("retune_busy", busy, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, '0, '0, 0);

    // Config held during SETTLE is only taken once RUN is reached
    ret_before = retune_cnt;
    guard = 0;
    while (m_mode == M_SETTLE && guard < 40) begin
      cycle(1, 1, 1, 32'h1234_5678, 32'h0, 0);
      guard++;
    end
    check_eq("held_reached_run", m_mode == M_RUN, 1);
    check_eq("held_not_taken", retune_cnt, ret_before);
    cycle(1, 1, 1, 32'h1234_5678, 32'h0, 0);
    check_eq("held_taken_once", retune_cnt, ret_before + 1'b1);

    // Enable dropped mid-SETTLE with a config pending
    ret_before = retune_cnt;
    cycle(0, 1, 1, 32'hdead_beef, 32'h0, 0);
    check_eq("drop_retune", retune_cnt, ret_before);
    check_eq("drop_ovalid", out_valid, 0);
    check_eq("drop_busy", busy, 0);

    // Gapped samples still need SN accepted samples to settle
    cycle(0, 0, 1, 32'h0100_0000, 32'h0000_0010, 1);
    cycle(1, 0, 0, '0, '0, 0);
    settle_run(80, 4, 0);

    // Asynchronous reset mid-RUN
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    enable = 0; smp_valid = 0; cfg_valid = 0;
    #12 reset_n = 1'b1;
    idle_cycles(3);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom, $urandom, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule : tb_ddc_ctrl
